// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// Module: bus_arbiter
//
// Purpose
//   Two-master bus arbiter. It takes level requests from master 0 (M0) and
//   master 1 (M1) and issues one-hot, registered grants. It also drives the
//   select line of the master-side 2:1 bus mux. M0 has fixed priority over M1.
//
//   Compile-time option: define BUS_ARB_TIMEOUT_EN to enable the hold timeout.
//   When it is enabled, an owner that has held the bus for MAX_HOLD
//   consecutive cycles loses it on the next edge if the other master is
//   waiting. The forced handover is flagged with a one-cycle arb_timeout
//   pulse. When the macro is left undefined, the hold counter is not built
//   and arb_timeout is tied to 0.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles before a forced handover (2..2**CNT_W)
//   CNT_W     width of the hold counter
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   m0_req       in   M0 bus request (level)
//   m1_req       in   M1 bus request (level)
//   m0_grant     out  M0 owns the bus (registered)
//   m1_grant     out  M1 owns the bus (registered)
//   m_sel        out  mux select, 0 = M0, 1 = M1 (registered)
//   arb_timeout  out  one-cycle pulse on a forced handover
// ----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic m_sel,
    output logic arb_timeout
);

    // Catch an illegal configuration at elaboration time: the counter must be
    // wide enough to reach MAX_HOLD-1, and a hold limit of one cycle is not supported.
    if (MAX_HOLD < 2 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_params
        $error("bus_arbiter: MAX_HOLD must be 2..2**CNT_W");
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] M0_GNT = 2'd1;
    localparam logic [1:0] M1_GNT = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       m0_grant_q;
    logic       m1_grant_q;
    logic       m_sel_q;

    // High when the current owner must give up the bus this edge even though
    // it is still requesting. This signal is always 0 when the timeout is compiled out.
    logic       force_handover;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             hold_full;
    logic             arb_timeout_q;

    // The counter saturates at MAX_HOLD-1. Reaching that value means the owner
    // has already held the bus for MAX_HOLD cycles, counting the cycle in progress.
    assign hold_full = (hold_cnt_q == HOLD_LAST);

    // A forced handover needs three conditions: a granted state, a saturated
    // counter, and both masters requesting. If the owner had dropped its
    // request, the normal release path would apply instead.
    assign force_handover = hold_full && m0_req && m1_req &&
                            ((state_q == M0_GNT) || (state_q == M1_GNT));

    // The counter clears on every state change and while idle. Otherwise it
    // counts the cycles spent in the same granted state and stops at the limit.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if ((state_d != state_q) || (state_d == IDLE)) begin
            hold_cnt_d = '0;
        end else if (!hold_full) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q    <= '0;
            arb_timeout_q <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            arb_timeout_q <= force_handover;
        end
    end

    assign arb_timeout = arb_timeout_q;
`else
    assign force_handover = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

    // Next-state logic.
    // - From IDLE, M0 wins a tie.
    // - An owner that drops its request hands the bus directly to a waiting
    //   peer, or returns to IDLE if no peer is waiting.
    // - A forced handover moves the grant to the peer that is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req) begin
                    state_d = M0_GNT;
                end else if (m1_req) begin
                    state_d = M1_GNT;
                end
            end
            M0_GNT: begin
                if (!m0_req) begin
                    state_d = m1_req ? M1_GNT : IDLE;
                end else if (force_handover) begin
                    state_d = M1_GNT;
                end
            end
            M1_GNT: begin
                if (!m1_req) begin
                    state_d = m0_req ? M0_GNT : IDLE;
                end else if (force_handover) begin
                    state_d = M0_GNT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The outputs are registered from the next-state decode. As a result, both
    // grants and the mux select always change on the same edge as the state.
    // The two grant flops are decoded from one state value, so they can never
    // both be high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
            m_sel_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == M0_GNT);
            m1_grant_q <= (state_d == M1_GNT);
            m_sel_q    <= (state_d == M1_GNT);
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;
    assign m_sel    = m_sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for bus_arbiter.
// A behavioural model tracks which master owns the bus and how many cycles
// it has held it. A compare process checks every DUT output against that
// model on each falling edge. Directed scenarios use literal expectations,
// and a randomized phase follows them.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 2;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic m0_req  = 1'b0;
    logic m1_req  = 1'b0;
    logic m0_grant;
    logic m1_grant;
    logic m_sel;
    logic arb_timeout;

    int total = 0;
    int bad   = 0;
    bit cmpEn = 1'b0;

    // Model state: owner 0 = nobody, 1 = M0, 2 = M1; held = grant cycles so far
    int mOwner = 0;
    int mHeld  = 0;
    bit mPulse = 1'b0;
    int mNext;
    bit mForce;
    bit mOwnReq;
    bit mOtherReq;
    int mOther;

    always #5 clk = ~clk;

    bus_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .m_sel      (m_sel),
        .arb_timeout(arb_timeout)
    );

    // The reference model works in terms of ownership and elapsed hold time.
    // An owner that has held the bus for MAX_HOLD cycles yields to a waiting
    // peer when the timeout is built in.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mOwner = 0;
            mHeld  = 0;
            mPulse = 1'b0;
        end else begin
            mNext  = mOwner;
            mForce = 1'b0;
            if (mOwner == 0) begin
                mNext = m0_req ? 1 : (m1_req ? 2 : 0);
            end else begin
                mOwnReq   = (mOwner == 1) ? m0_req : m1_req;
                mOtherReq = (mOwner == 1) ? m1_req : m0_req;
                mOther    = 3 - mOwner;
                if (!mOwnReq) begin
                    mNext = mOtherReq ? mOther : 0;
                end else if (TO_EN && mHeld >= MAX_HOLD && mOtherReq) begin
                    mNext  = mOther;
                    mForce = 1'b1;
                end
            end
            mHeld  = (mNext == 0) ? 0 : ((mNext == mOwner) ? mHeld + 1 : 1);
            mOwner = mNext;
            mPulse = mForce;
        end
    end

    task automatic checkOne(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOne("model.m0_grant", m0_grant, mOwner == 1);
            checkOne("model.m1_grant", m1_grant, mOwner == 2);
            checkOne("model.m_sel", m_sel, mOwner == 2);
            checkOne("model.arb_timeout", arb_timeout, mPulse);
            checkOne("model.exclusive", m0_grant & m1_grant, 1'b0);
        end
    end

    task automatic checkOutput(input string name, input logic e0, input logic e1,
                               input logic es, input logic et);
        checkOne($sformatf("%s.m0_grant", name), m0_grant, e0);
        checkOne($sformatf("%s.m1_grant", name), m1_grant, e1);
        checkOne($sformatf("%s.m_sel", name), m_sel, es);
        checkOne($sformatf("%s.arb_timeout", name), arb_timeout, et);
    endtask

    // This task is called at a falling edge. It drives the requests shortly
    // after that edge, then returns at the next falling edge, once the rising
    // edge in between has sampled them.
    task automatic applyStimulus(input logic r0, input logic r1);
        #1;
        m0_req = r0;
        m1_req = r1;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start, timeout build = %0d", TO_EN);
        cmpEn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests from IDLE: M0 wins
        applyStimulus(1'b1, 1'b1);
        checkOutput("tie", 1'b1, 1'b0, 1'b0, 1'b0);

        // M0 releases while M1 waits: direct handover
        applyStimulus(1'b0, 1'b1);
        checkOutput("handover", 1'b0, 1'b1, 1'b1, 1'b0);

        // Both released: back to IDLE
        applyStimulus(1'b0, 1'b0);
        checkOutput("release", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reasserted together: priority again
        applyStimulus(1'b1, 1'b1);
        checkOutput("reprio", 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 2; k <= MAX_HOLD; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("forced", 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("after_forced", 1'b0, 1'b1, 1'b1, 1'b0);
`else
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("no_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
        end
`endif

        // Get into M1_GNT, then apply an asynchronous reset mid-cycle
        applyStimulus(1'b0, 1'b1);
        checkOutput("m1_owner", 1'b0, 1'b1, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized phase: requests toggle occasionally, so long holds and
        // contention both occur. Rare asynchronous resets are mixed in.
        for (int c = 0; c < 3000; c++) begin
            #1;
            if ($urandom_range(5, 0) == 0) m0_req = ~m0_req;
            if ($urandom_range(5, 0) == 0) m1_req = ~m1_req;
            if ($urandom_range(399, 0) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
